fifo_pack_flush: RTL and testbench
==================================

# fifo_pack_flush

Parametrised narrow-to-wide packing FIFO with a flush handshake: accepts IN_W-bit write lanes, packs RATIO lanes into one OUT_W-bit word and buffers DEPTH words for a first-word-fall-through reader. A flush request either zero-pads and commits the partial word (pad mode) or discards all held data (discard mode), then signals completion. It is the next-generation replacement for the fixed 4-to-32-bit flush FIFO on the same datapath.

## Interface
- IN_W, 4, write lane width in bits
- RATIO, 8, lanes per output word; OUT_W = IN_W*RATIO
- DEPTH, 4, word storage depth; power of two, ≥2
- FLUSH_MODE, 0, 0 = pad-and-commit partial word, 1 = discard everything
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- fifo_wr_valid_i  in  1  write lane strobe
- fifo_wr_data_i  in  IN_W  write lane data
- fifo_rd_valid_i  in  1  pop head word
- fifo_flush_i  in  1  flush request (level)
- fifo_rd_data_o  out  OUT_W  head word, lane 0 at LSBs; zero when no word stored
- fifo_rd_count_o  out  $clog2(RATIO+1)  valid lanes in head word (RATIO for full words)
- fifo_data_avail_o  out  1  ≥1 word stored
- fifo_empty_o  out  1  no words stored and packer empty
- fifo_full_o  out  1  DEPTH words stored
- fifo_flush_done_o  out  1  flush complete
- fifo_wr_drop_o  out  1  one-cycle pulse: write in the previous cycle was discarded

## Operation
- Packer: lane register plus lane counter; accepted lane k written at bits [k*IN_W +: IN_W].
- Write accepted iff fifo_wr_valid_i, state IDLE and !fifo_full_o; otherwise dropped and fifo_wr_drop_o pulses next cycle.
- On accepting lane RATIO-1, the completed word (count RATIO) is pushed in the same edge; packer clears.
- fifo_full_o uses the registered word count; a same-cycle pop does not unblock a write.
- Read: pop at edge when fifo_rd_valid_i && fifo_data_avail_o; read while empty is ignored; simultaneous push and pop keeps the count unchanged.
- Flush FSM: IDLE, FLUSH, DONE.
  - IDLE→FLUSH when fifo_flush_i is sampled high; a write in that same cycle is still accepted and included in the flush.
  - FLUSH, mode 0: packer empty → DONE, no push; packer non-empty and !full → push zero-padded word with count = lanes held, clear packer, → DONE; full → stay in FLUSH until a pop frees a slot.
  - FLUSH, mode 1: clear packer and word storage in one edge → DONE.
  - DONE: fifo_flush_done_o high; → IDLE when fifo_flush_i is sampled low.
- Writes in FLUSH or DONE are dropped (with drop pulse); reads remain legal in all states.

## Timing
- Reset values: all counts 0; fifo_empty_o 1; fifo_data_avail_o, fifo_full_o, fifo_flush_done_o, fifo_wr_drop_o 0; fifo_rd_data_o 0; fifo_rd_count_o 0; FSM IDLE.
- Last lane accepted at edge N: fifo_data_avail_o high from edge N.
- Flush sampled at edge N (FLUSH); commit/clear at edge N+1 (DONE); fifo_flush_done_o high from edge N+1 while not blocked by full.
- fifo_rd_data_o and fifo_rd_count_o are combinational from the head slot; the pop advances at the same edge.
- Read and write pointers wrap modulo DEPTH; the word count is $clog2(DEPTH)+1 bits.
- Reset mid-flush: FSM to IDLE and all storage cleared at that edge.

## Structure
- Package fifo_flush_pkg: FSM state enum (IDLE/FLUSH/DONE) and FLUSH_MODE constants (MODE_PAD, MODE_DISCARD).
- Sub-module fifo_word_store: DEPTH×(OUT_W + count) circular buffer with push/pop/clear, full/avail flags. The top level holds the packer and the FSM.

## Test plan
Defaults IN_W=4, RATIO=8, DEPTH=4 unless stated.
- Reset held 2 cycles -> every output at its reset value; fifo_empty_o=1.
- Write lanes 1,2,…,8 on consecutive cycles -> after the 8th edge fifo_rd_data_o=0x87654321, fifo_rd_count_o=8; one pop -> fifo_empty_o=1.
- Write A,6,8, then hold flush (mode 0) -> fifo_rd_data_o=0x0000086A, fifo_rd_count_o=3, fifo_flush_done_o high 2 edges after flush, low one cycle after flush drops.
- 32 lane writes, then a 33rd write -> fifo_full_o=1, fifo_wr_drop_o pulses once, stored words unchanged; one pop -> fifo_full_o=0.
- FLUSH_MODE=1: 2 words + 3 lanes, then flush -> fifo_empty_o=1, fifo_rd_data_o=0 at DONE.
- Writes during FLUSH/DONE -> dropped with a pulse each; reset asserted while in FLUSH -> IDLE with all outputs at reset values.

Source files
------------

// File: rtl/fifo_flush_pkg.sv
// Shared types for the packing flush FIFO: flush FSM states and flush-mode encodings.
package fifo_flush_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  localparam int MODE_PAD     = 0;
  localparam int MODE_DISCARD = 1;

endpackage

// File: rtl/fifo_word_store.sv
// Circular word buffer holding packed words plus their valid-lane counts.
// The head slot is presented combinationally and reads as zero when nothing is stored.
module fifo_word_store #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic [CNT_W-1:0]  i_push_cnt,
  input  logic              i_pop,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CNT_W-1:0]  o_head_cnt,
  output logic              o_avail,
  output logic              o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [CNT_W-1:0]  r_cnt  [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_words;

  logic w_full;
  logic w_avail;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_words == (AW+1)'(DEPTH));
  assign w_avail   = (r_words != '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && w_avail;

  always_ff @(posedge clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_words  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_words <= r_words + 1'b1;
      else if (!w_do_push && w_do_pop) r_words <= r_words - 1'b1;
    end
  end

  // Slot contents need no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_reset && !i_clear) begin
      r_data[r_wr_ptr] <= i_push_data;
      r_cnt[r_wr_ptr]  <= i_push_cnt;
    end
  end

  assign o_head_data = w_avail ? r_data[r_rd_ptr] : '0;
  assign o_head_cnt  = w_avail ? r_cnt[r_rd_ptr]  : '0;
  assign o_avail     = w_avail;
  assign o_full      = w_full;

endmodule

// File: rtl/fifo_pack_flush.sv
// Narrow-to-wide packing FIFO with flush handshake (pad-and-commit or discard).
//   state | meaning
//   IDLE  | packing accepted lanes, watching for a flush request
//   FLUSH | committing the partial word (pad) or clearing all held data (discard)
//   DONE  | flush complete, waiting for the request to drop
module fifo_pack_flush
  import fifo_flush_pkg::*;
#(
  parameter int IN_W       = 4,
  parameter int RATIO      = 8,
  parameter int DEPTH      = 4,
  parameter int FLUSH_MODE = MODE_PAD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fifo_wr_valid_i,
  input  logic [IN_W-1:0]              fifo_wr_data_i,
  input  logic                         fifo_rd_valid_i,
  input  logic                         fifo_flush_i,
  output logic [IN_W*RATIO-1:0]        fifo_rd_data_o,
  output logic [$clog2(RATIO+1)-1:0]   fifo_rd_count_o,
  output logic                         fifo_data_avail_o,
  output logic                         fifo_empty_o,
  output logic                         fifo_full_o,
  output logic                         fifo_flush_done_o,
  output logic                         fifo_wr_drop_o
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  flush_state_e r_state;
  flush_state_e w_state_next;

  logic [OUT_W-1:0] r_lanes;
  logic [CW-1:0]    r_lane_cnt;
  logic             r_drop;

  logic             w_full;
  logic             w_avail;
  logic             w_accept;
  logic             w_last_lane;
  logic [OUT_W-1:0] w_packed;
  logic             w_push;
  logic [OUT_W-1:0] w_push_data;
  logic [CW-1:0]    w_push_cnt;
  logic             w_store_clear;
  logic             w_pack_clear;

  assign w_accept    = fifo_wr_valid_i && (r_state == IDLE) && !w_full;
  assign w_last_lane = (r_lane_cnt == CW'(RATIO - 1));

  // Packer contents with the incoming lane merged in at the current lane slot.
  always_comb begin
    w_packed = r_lanes;
    for (int k = 0; k < RATIO; k++) begin
      if (r_lane_cnt == CW'(k)) w_packed[k*IN_W +: IN_W] = fifo_wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_push        = 1'b0;
    w_push_data   = w_packed;
    w_push_cnt    = CW'(RATIO);
    w_store_clear = 1'b0;
    w_pack_clear  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_last_lane) begin
          w_push       = 1'b1;
          w_pack_clear = 1'b1;
        end
        if (fifo_flush_i) w_state_next = FLUSH;
      end
      FLUSH: begin
        if (FLUSH_MODE == MODE_DISCARD) begin
          w_store_clear = 1'b1;
          w_pack_clear  = 1'b1;
          w_state_next  = DONE;
        end else if (r_lane_cnt == '0) begin
          w_state_next = DONE;
        end else if (!w_full) begin
          // Unused upper lanes are already zero because the packer clears on every commit.
          w_push       = 1'b1;
          w_push_data  = r_lanes;
          w_push_cnt   = r_lane_cnt;
          w_pack_clear = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (!fifo_flush_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lanes    <= '0;
      r_lane_cnt <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= fifo_wr_valid_i && !w_accept;
      if (w_pack_clear) begin
        r_lanes    <= '0;
        r_lane_cnt <= '0;
      end else if (w_accept) begin
        r_lanes    <= w_packed;
        r_lane_cnt <= r_lane_cnt + 1'b1;
      end
    end
  end

  fifo_word_store #(
    .DATA_W (OUT_W),
    .CNT_W  (CW),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk         (clk),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_push_cnt  (w_push_cnt),
    .i_pop       (fifo_rd_valid_i),
    .i_clear     (w_store_clear),
    .o_head_data (fifo_rd_data_o),
    .o_head_cnt  (fifo_rd_count_o),
    .o_avail     (w_avail),
    .o_full      (w_full)
  );

  assign fifo_data_avail_o = w_avail;
  assign fifo_full_o       = w_full;
  assign fifo_empty_o      = !w_avail && (r_lane_cnt == '0);
  assign fifo_flush_done_o = (r_state == DONE);
  assign fifo_wr_drop_o    = r_drop;

endmodule

// File: tb/tb_fifo_pack_flush.sv
// Directed bench for fifo_pack_flush: a pad-mode instance driven from a vector table
// plus hand-written sequences, and a discard-mode instance for the discard flush.
module tb_fifo_pack_flush;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wv, rv, fl;
  logic [3:0]  wd;
  logic [31:0] rd;
  logic [3:0]  rc;
  logic        av, em, fu, dn, dr;

  logic        reset1, wv1, rv1, fl1;
  logic [3:0]  wd1;
  logic [31:0] rd1;
  logic [3:0]  rc1;
  logic        av1, em1, fu1, dn1, dr1;

  int n_pass  = 0;
  int n_total = 0;

  fifo_pack_flush #(.IN_W(4), .RATIO(8), .DEPTH(4), .FLUSH_MODE(0)) dut (
    .clk(clk), .reset(reset), .fifo_wr_valid_i(wv), .fifo_wr_data_i(wd),
    .fifo_rd_valid_i(rv), .fifo_flush_i(fl), .fifo_rd_data_o(rd), .fifo_rd_count_o(rc),
    .fifo_data_avail_o(av), .fifo_empty_o(em), .fifo_full_o(fu),
    .fifo_flush_done_o(dn), .fifo_wr_drop_o(dr)
  );

  fifo_pack_flush #(.IN_W(4), .RATIO(8), .DEPTH(4), .FLUSH_MODE(1)) dut1 (
    .clk(clk), .reset(reset1), .fifo_wr_valid_i(wv1), .fifo_wr_data_i(wd1),
    .fifo_rd_valid_i(rv1), .fifo_flush_i(fl1), .fifo_rd_data_o(rd1), .fifo_rd_count_o(rc1),
    .fifo_data_avail_o(av1), .fifo_empty_o(em1), .fifo_full_o(fu1),
    .fifo_flush_done_o(dn1), .fifo_wr_drop_o(dr1)
  );

  typedef struct {
    logic        wv;
    logic [3:0]  wd;
    logic        rv;
    logic        fl;
    logic [31:0] d;
    logic [3:0]  c;
    logic        av;
    logic        em;
    logic        fu;
    logic        dn;
    logic        dr;
  } vec_t;

  vec_t vecs[$];

  // Word w of the fill pattern carries lane values w, w+1, ... w+7 (mod 16).
  function automatic logic [31:0] word_val(int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = 4'(w + k);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all(string tag, logic [31:0] d, logic [3:0] c,
                         logic a, logic e, logic f, logic dn_e, logic dr_e);
    chk({tag, " rd_data"}, rd, d);
    chk({tag, " rd_count"}, {28'd0, rc}, {28'd0, c});
    chk({tag, " avail"}, {31'd0, av}, {31'd0, a});
    chk({tag, " empty"}, {31'd0, em}, {31'd0, e});
    chk({tag, " full"}, {31'd0, fu}, {31'd0, f});
    chk({tag, " flush_done"}, {31'd0, dn}, {31'd0, dn_e});
    chk({tag, " wr_drop"}, {31'd0, dr}, {31'd0, dr_e});
  endtask

  task automatic cyc(logic w, logic [3:0] d, logic r, logic f);
    wv = w; wd = d; rv = r; fl = f;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(logic w, logic [3:0] d, logic r, logic f);
    wv1 = w; wd1 = d; rv1 = r; fl1 = f;
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic w, logic [3:0] d, logic r, logic f, logic [31:0] xd,
                     logic [3:0] xc, logic xa, logic xe, logic xf, logic xdn, logic xdr);
    vec_t v;
    v.wv = w; v.wd = d; v.rv = r; v.fl = f;
    v.d = xd; v.c = xc; v.av = xa; v.em = xe; v.fu = xf; v.dn = xdn; v.dr = xdr;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; wv = 1'b0; wd = '0; rv = 1'b0; fl = 1'b0;
    reset1 = 1'b1; wv1 = 1'b0; wd1 = '0; rv1 = 1'b0; fl1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset dut1 empty", {31'd0, em1}, 32'd1);
    reset = 1'b0;
    reset1 = 1'b0;

    //  wv  wd     rv  fl   data          cnt  av  em  fu  dn  dr
    for (int i = 0; i < 7; i++)
      add(1, 4'(i + 1), 0, 0, 32'h0, 4'd0, 0, 0, 0, 0, 0);
    add(1, 4'h8, 0, 0, 32'h87654321, 4'd8, 1, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        4'd0, 0, 1, 0, 0, 0);
    // partial word A,6,8 then pad flush
    add(1, 4'hA, 0, 0, 32'h0,        4'd0, 0, 0, 0, 0, 0);
    add(1, 4'h6, 0, 0, 32'h0,        4'd0, 0, 0, 0, 0, 0);
    add(1, 4'h8, 0, 0, 32'h0,        4'd0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 0, 1, 32'h0,        4'd0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 0, 1, 32'h0000086A, 4'd3, 1, 0, 0, 1, 0);
    add(0, 4'h0, 0, 0, 32'h0000086A, 4'd3, 1, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        4'd0, 0, 1, 0, 0, 0);
    // write in the flush cycle is kept; writes in FLUSH/DONE are dropped
    add(1, 4'h5, 0, 1, 32'h0,        4'd0, 0, 0, 0, 0, 0);
    add(1, 4'h9, 0, 1, 32'h00000005, 4'd1, 1, 0, 0, 1, 1);
    add(1, 4'h3, 0, 1, 32'h00000005, 4'd1, 1, 0, 0, 1, 1);
    add(0, 4'h0, 0, 0, 32'h00000005, 4'd1, 1, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        4'd0, 0, 1, 0, 0, 0);
    // flush with empty packer commits nothing
    add(0, 4'h0, 0, 1, 32'h0,        4'd0, 0, 1, 0, 0, 0);
    add(0, 4'h0, 0, 0, 32'h0,        4'd0, 0, 1, 0, 1, 0);
    add(0, 4'h0, 0, 0, 32'h0,        4'd0, 0, 1, 0, 0, 0);
    // read while empty is ignored
    add(0, 4'h0, 1, 0, 32'h0,        4'd0, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].wv, vecs[i].wd, vecs[i].rv, vecs[i].fl);
      chk_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].c, vecs[i].av,
              vecs[i].em, vecs[i].fu, vecs[i].dn, vecs[i].dr);
    end

    // Fill all four words, then overrun.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 4'((i / 8) + (i % 8)), 1'b0, 1'b0);
      if (i == 30) chk("fill31 full", {31'd0, fu}, 32'd0);
    end
    chk_all("filled", word_val(0), 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    chk_all("overrun", word_val(0), 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk_all("overrun idle", word_val(0), 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'hC, 1'b1, 1'b0);
    chk_all("pop+write full", word_val(1), 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain w2", rd, word_val(2));
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain w3", rd, word_val(3));
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk_all("drained", 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Discard mode: 2 words + 3 lanes, then flush.
    for (int i = 0; i < 19; i++) cyc1(1'b1, 4'((i / 8) + (i % 8)), 1'b0, 1'b0);
    chk("m1 pre avail", {31'd0, av1}, 32'd1);
    chk("m1 pre data", rd1, word_val(0));
    cyc1(1'b0, 4'h0, 1'b0, 1'b1);
    chk("m1 flush data", rd1, word_val(0));
    chk("m1 flush done", {31'd0, dn1}, 32'd0);
    cyc1(1'b0, 4'h0, 1'b0, 1'b1);
    chk("m1 done empty", {31'd0, em1}, 32'd1);
    chk("m1 done data", rd1, 32'h0);
    chk("m1 done count", {28'd0, rc1}, 32'd0);
    chk("m1 done avail", {31'd0, av1}, 32'd0);
    chk("m1 done flag", {31'd0, dn1}, 32'd1);
    cyc1(1'b0, 4'h0, 1'b0, 1'b0);
    chk("m1 idle done", {31'd0, dn1}, 32'd0);
    cyc1(1'b1, 4'h7, 1'b0, 1'b0);
    chk("m1 write after", {31'd0, em1}, 32'd0);
    chk("m1 write drop", {31'd0, dr1}, 32'd0);

    // Reset while in FLUSH.
    cyc(1'b1, 4'h1, 1'b0, 1'b0);
    cyc(1'b1, 4'h2, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("pre-reset flush done", {31'd0, dn}, 32'd0);
    reset = 1'b1;
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk_all("reset in flush", 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("post-reset done", {31'd0, dn}, 32'd0);
    chk("post-reset empty", {31'd0, em}, 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("post-reset idle", {31'd0, dn}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
